// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_ctrl_pkg
// Description : Shared state encodings and PC constants for instruction fetch.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2
    } pc_state_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    localparam int unsigned PC_INC     = 4;
    localparam logic [31:0] ALIGN_MASK = ~32'h3;

endpackage : pc_ctrl_pkg
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_sel
// Description : Priority select of the next PC: jump, then branch, then PC+4.
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_sel
    import pc_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] next_pc
);

    // Mask built from the inverted low bits so it stays correct at any width.
    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(~ALIGN_MASK);
    localparam logic [ADDR_W-1:0] c_pc_inc     = ADDR_W'(PC_INC);

    always_comb begin
        next_pc = pc + c_pc_inc;
        if (jump) begin
            next_pc = jump_target & c_align_mask;
        end else if (br_taken) begin
            next_pc = br_target & c_align_mask;
        end
    end

endmodule : next_pc_sel
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Program counter and req/ack instruction fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer
    import pc_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic              r_instr_valid;
    logic [ADDR_W-1:0] r_pc_out;
    logic [ADDR_W-1:0] w_next_pc;

    next_pc_sel #(
        .ADDR_W      (ADDR_W)
    ) u_next_pc_sel (
        .pc          (r_pc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .next_pc     (w_next_pc)
    );

    // Request is decoded from state so an async reset drops it immediately.
    assign imem_req    = (r_state == ST_REQ);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc_out      = r_pc_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_pc_out      <= RESET_PC;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_pc_out      <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Redirects only take effect on the cycle ISSUE is released.
                    if (!stall) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : pc_fetch_sequencer
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_sequencer
// Description : Directed self-checking bench for pc_fetch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_w;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;

    logic        imem_req,   req_w;
    logic [31:0] imem_addr,  addr_w;
    logic [31:0] instr,      instr_w;
    logic        instr_valid, valid_w;
    logic [31:0] pc_out,     pcout_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .pc_out(pc_out), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .jump(jump),
        .jump_target(jump_target)
    );

    pc_fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst_w), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr_w),
        .instr_valid(valid_w), .pc_out(pcout_w), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .jump(jump),
        .jump_target(jump_target)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rst_w = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
        #3;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc_out got %h exp 0", pc_out); end
        checks++; if (pcout_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_pc_out_w got %h exp fffffffc", pcout_w); end
        tick; tick;
        rst = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", imem_req); end
        tick;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
    endtask

    task automatic test_zero_wait;
        logic [31:0] exp_addr;
        for (int i = 0; i < 4; i++) begin
            exp_addr = 32'(i * 4);
            checks++; if (imem_addr !== exp_addr || imem_req !== 1'b1) begin errors++; $display("FAIL zw_addr[%0d] got %h/%b exp %h/1", i, imem_addr, imem_req, exp_addr); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL zw_valid_lo[%0d] got %b exp 0", i, instr_valid); end
            imem_ack = 1'b1; imem_rdata = 32'hC0DE_0000 | exp_addr;
            tick;
            imem_ack = 1'b0;
            checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL zw_valid_hi[%0d] got %b/%b exp 1/0", i, instr_valid, imem_req); end
            checks++; if (instr !== (32'hC0DE_0000 | exp_addr) || pc_out !== exp_addr) begin errors++; $display("FAIL zw_instr[%0d] got %h@%h exp %h@%h", i, instr, pc_out, 32'hC0DE_0000 | exp_addr, exp_addr); end
            tick;
        end
    endtask

    task automatic test_wait_states;
        rst = 1'b1; tick; rst = 1'b0; tick;
        imem_ack = 1'b1; imem_rdata = 32'hA000_0000;
        tick; imem_ack = 1'b0; tick;
        for (int k = 0; k < 4; k++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL ws_req[%0d] got %b@%h exp 1@00000004", k, imem_req, imem_addr); end
            if (k < 3) begin imem_ack = 1'b0; imem_rdata = 32'hDEAD_0000 + 32'(k); end
            else begin imem_ack = 1'b1; imem_rdata = 32'h1234_5678; end
            tick;
        end
        imem_ack = 1'b0;
        checks++; if (instr !== 32'h1234_5678 || pc_out !== 32'h4) begin errors++; $display("FAIL ws_instr got %h@%h exp 12345678@00000004", instr, pc_out); end
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin errors++; $display("FAIL ws_issue got req %b valid %b exp 0/1", imem_req, instr_valid); end
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick;
        checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL ws_ack_outside_req got %h exp 12345678", instr); end
        stall = 1'b0; imem_ack = 1'b0;
        tick;
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL ws_next_addr got %h exp 00000008", imem_addr); end
    endtask

    task automatic test_branch;
        imem_ack = 1'b1; imem_rdata = 32'h0000_0808;
        tick; imem_ack = 1'b0;
        checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL br_pc_out got %h exp 00000008", pc_out); end
        br_taken = 1'b1; br_target = 32'h40;
        tick; br_taken = 1'b0;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_addr got %h exp 00000040", imem_addr); end
        imem_ack = 1'b1; tick; imem_ack = 1'b0;
        jump = 1'b1; jump_target = 32'h8;
        tick; jump = 1'b0;
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL jmp_addr got %h exp 00000008", imem_addr); end
        imem_ack = 1'b1; tick; imem_ack = 1'b0;
        br_taken = 1'b1; br_target = 32'h43;
        tick; br_taken = 1'b0;
        checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL br_align got %h/%b exp 00000040/1", imem_addr, imem_req); end
    endtask

    task automatic test_priority_stall;
        imem_ack = 1'b1; imem_rdata = 32'h4040_4040;
        tick; imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ps_valid0 got %b exp 1", instr_valid); end
        stall = 1'b1; jump = 1'b1; jump_target = 32'h100; br_taken = 1'b1; br_target = 32'h40;
        for (int s = 0; s < 2; s++) begin
            tick;
            checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL ps_valid[%0d] got %b/%b exp 1/0", s, instr_valid, imem_req); end
            checks++; if (imem_addr !== 32'h40 || pc_out !== 32'h40 || instr !== 32'h4040_4040) begin errors++; $display("FAIL ps_frozen[%0d] got %h %h %h", s, imem_addr, pc_out, instr); end
        end
        stall = 1'b0;
        tick;
        jump = 1'b0; br_taken = 1'b0;
        checks++; if (imem_addr !== 32'h100 || instr_valid !== 1'b0) begin errors++; $display("FAIL ps_jump_wins got %h/%b exp 00000100/0", imem_addr, instr_valid); end
        jump = 1'b1; jump_target = 32'h200; br_taken = 1'b1; br_target = 32'h300;
        tick;
        jump = 1'b0; br_taken = 1'b0;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL ps_req_redirect got %h exp 00000100", imem_addr); end
        imem_ack = 1'b1; tick; imem_ack = 1'b0; tick;
        checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL ps_seq got %h exp 00000104", imem_addr); end
    endtask

    task automatic test_wrap_reset;
        rst = 1'b1; rst_w = 1'b0;
        tick;
        checks++; if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_first got %b@%h exp 1@fffffffc", req_w, addr_w); end
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_0001;
        tick; imem_ack = 1'b0;
        checks++; if (valid_w !== 1'b1 || pcout_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_issue got %b@%h exp 1@fffffffc", valid_w, pcout_w); end
        tick;
        checks++; if (addr_w !== 32'h0 || req_w !== 1'b1) begin errors++; $display("FAIL wr_wrap got %h/%b exp 00000000/1", addr_w, req_w); end
        imem_ack = 1'b1; imem_rdata = 32'hBEEF_BEEF;
        #2; rst_w = 1'b1; #1;
        checks++; if (req_w !== 1'b0) begin errors++; $display("FAIL wr_rst_req got %b exp 0", req_w); end
        tick;
        checks++; if (instr_w !== 32'h0 || valid_w !== 1'b0) begin errors++; $display("FAIL wr_ack_discard got %h/%b exp 00000000/0", instr_w, valid_w); end
        imem_ack = 1'b0; rst_w = 1'b0;
        tick;
        checks++; if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_refetch got %b@%h exp 1@fffffffc", req_w, addr_w); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_zero_wait;
        test_wait_states;
        test_branch;
        test_priority_stall;
        test_wrap_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_fetch_sequencer
`default_nettype wire
